// File: rtl/cc_producer_unit.sv
// SPARC icc producer: carries cc-setting ALU results from EX through MEM/WB,
// commits them to the architectural icc and forwards the newest value to ID.
module cc_producer_unit #(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_cc_we,
    input  logic [FLAG_W-1:0] ex_flags,
    input  logic              flush,
    input  logic              psr_we,
    input  logic [FLAG_W-1:0] psr_wdata,
    output logic [FLAG_W-1:0] flags_out,
    output logic [FLAG_W-1:0] icc,
    output logic              cc_pending
);

    logic              mem_v_q, mem_v_d;
    logic [FLAG_W-1:0] mem_f_q, mem_f_d;
    logic              wb_v_q,  wb_v_d;
    logic [FLAG_W-1:0] wb_f_q,  wb_f_d;
    logic [FLAG_W-1:0] icc_q,   icc_d;
    logic              ex_live;

    always_comb begin
        ex_live = ex_valid & ex_cc_we & ~flush & ~reset;
        mem_v_d = ex_live;
        mem_f_d = ex_flags;
        // The WB entry is older than any flush source, so only MEM is dropped.
        wb_v_d  = mem_v_q & ~flush;
        wb_f_d  = mem_f_q;
        icc_d   = icc_q;
        if (psr_we) begin
            icc_d = psr_wdata;
        end else if (wb_v_q) begin
            icc_d = wb_f_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_v_q <= 1'b0;
            mem_f_q <= '0;
            wb_v_q  <= 1'b0;
            wb_f_q  <= '0;
            icc_q   <= '0;
        end else begin
            mem_v_q <= mem_v_d;
            mem_f_q <= mem_f_d;
            wb_v_q  <= wb_v_d;
            wb_f_q  <= wb_f_d;
            icc_q   <= icc_d;
        end
    end

    // Newest in-flight value first; a flushing cycle hides the EX and MEM sources.
    always_comb begin
        flags_out = icc_q;
        if (ex_live) begin
            flags_out = ex_flags;
        end else if (mem_v_q && !flush) begin
            flags_out = mem_f_q;
        end else if (wb_v_q) begin
            flags_out = wb_f_q;
        end else if (psr_we) begin
            flags_out = psr_wdata;
        end
    end

    assign icc        = icc_q;
    assign cc_pending = mem_v_q | wb_v_q;

endmodule

// File: tb/tb_cc_producer_unit.sv
// Self-checking bench for cc_producer_unit: directed vector table plus
// randomized traffic checked against a per-issue-cycle history model.
module tb_cc_producer_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic       ex_cc_we;
    logic [3:0] ex_flags;
    logic       flush;
    logic       psr_we;
    logic [3:0] psr_wdata;
    logic [3:0] flags_out;
    logic [3:0] icc;
    logic       cc_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cc_producer_unit #(.FLAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_cc_we  (ex_cc_we),
        .ex_flags  (ex_flags),
        .flush     (flush),
        .psr_we    (psr_we),
        .psr_wdata (psr_wdata),
        .flags_out (flags_out),
        .icc       (icc),
        .cc_pending(cc_pending)
    );

    typedef struct {
        logic       rst, v, we;
        logic [3:0] f;
        logic       fl, pw;
        logic [3:0] pd;
        logic       chk;
        logic [3:0] efo, eicc;
        logic       epend;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(logic rst, logic v, logic we, logic [3:0] f, logic fl,
                                logic pw, logic [3:0] pd, logic chk,
                                logic [3:0] efo, logic [3:0] eicc, logic epend);
        vec_t r;
        r.rst = rst; r.v = v; r.we = we; r.f = f; r.fl = fl; r.pw = pw; r.pd = pd;
        r.chk = chk; r.efo = efo; r.eicc = eicc; r.epend = epend;
        return r;
    endfunction

    task automatic check(input string name, input int cyc, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic we, input logic [3:0] f,
                         input logic fl, input logic pw, input logic [3:0] pd);
        @(negedge clk);
        reset = rst; ex_valid = v; ex_cc_we = we; ex_flags = f;
        flush = fl; psr_we = pw; psr_wdata = pd;
        #1;
    endtask

    // Model: alive[k]/flg[k] record the cc write issued in cycle k.
    localparam int NRND = 600;
    logic       alive[NRND + 4];
    logic [3:0] flg[NRND + 4];
    logic [3:0] icc_m;

    initial begin
        logic       rst, v, we, fl, pw;
        logic [3:0] f, pd, fo_exp;
        logic       pend_exp;

        reset = 1'b1; ex_valid = 1'b0; ex_cc_we = 1'b0; ex_flags = '0;
        flush = 1'b0; psr_we = 1'b0; psr_wdata = '0;

        //            rst v  we f     fl pw pd    chk fo    icc   pend
        tbl[0]  = mk(1, 0, 1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
        tbl[1]  = mk(1, 0, 1, 4'hF, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0);
        tbl[2]  = mk(0, 0, 1, 4'hF, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0);
        tbl[3]  = mk(0, 1, 1, 4'h1, 0, 0, 4'h0, 1, 4'h1, 4'h0, 0);
        tbl[4]  = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 4'h0, 1);
        tbl[5]  = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 4'h0, 1);
        tbl[6]  = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 4'h1, 0);
        tbl[7]  = mk(0, 1, 1, 4'h2, 0, 0, 4'h0, 1, 4'h2, 4'h1, 0);
        tbl[8]  = mk(0, 1, 1, 4'h4, 0, 0, 4'h0, 1, 4'h4, 4'h1, 1);
        tbl[9]  = mk(0, 1, 1, 4'h8, 0, 0, 4'h0, 1, 4'h8, 4'h1, 1);
        tbl[10] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h8, 4'h2, 1);
        tbl[11] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h8, 4'h4, 1);
        tbl[12] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h8, 4'h8, 0);
        tbl[13] = mk(0, 1, 1, 4'h1, 0, 0, 4'h0, 1, 4'h1, 4'h8, 0);
        tbl[14] = mk(0, 1, 1, 4'h2, 0, 0, 4'h0, 1, 4'h2, 4'h8, 1);
        tbl[15] = mk(0, 1, 1, 4'h4, 1, 0, 4'h0, 1, 4'h1, 4'h8, 1);
        tbl[16] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 4'h1, 0);
        tbl[17] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 4'h1, 0);
        tbl[18] = mk(0, 1, 1, 4'h3, 0, 0, 4'h0, 1, 4'h3, 4'h1, 0);
        tbl[19] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h3, 4'h1, 1);
        tbl[20] = mk(0, 0, 0, 4'h0, 0, 1, 4'hC, 1, 4'h3, 4'h1, 1);
        tbl[21] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'hC, 4'hC, 0);
        tbl[22] = mk(0, 0, 0, 4'h0, 0, 1, 4'h5, 1, 4'h5, 4'hC, 0);
        tbl[23] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h5, 4'h5, 0);
        tbl[24] = mk(0, 0, 1, 4'hF, 0, 0, 4'h0, 1, 4'h5, 4'h5, 0);
        tbl[25] = mk(0, 1, 1, 4'h6, 0, 0, 4'h0, 1, 4'h6, 4'h5, 0);
        tbl[26] = mk(0, 1, 1, 4'h7, 0, 0, 4'h0, 1, 4'h7, 4'h5, 1);
        tbl[27] = mk(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
        tbl[28] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0);
        tbl[29] = mk(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].we, tbl[i].f, tbl[i].fl, tbl[i].pw, tbl[i].pd);
            if (tbl[i].chk) begin
                check("vec_flags_out", i, flags_out, tbl[i].efo);
                check("vec_icc", i, icc, tbl[i].eicc);
                check("vec_cc_pending", i, {3'b0, cc_pending}, {3'b0, tbl[i].epend});
            end
        end

        for (int k = 0; k < NRND + 4; k++) begin
            alive[k] = 1'b0;
            flg[k]   = '0;
        end
        icc_m = '0;

        for (int c = 2; c < NRND + 2; c++) begin
            rst = (c == 2) || ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) != 0);
            f   = 4'($urandom_range(0, 15));
            fl  = ($urandom_range(0, 7) == 0);
            pw  = ($urandom_range(0, 9) == 0);
            pd  = 4'($urandom_range(0, 15));
            drive(rst, v, we, f, fl, pw, pd);

            pend_exp = alive[c-1] | alive[c-2];
            alive[c] = v & we & ~fl & ~rst;
            flg[c]   = f;
            if (fl) alive[c-1] = 1'b0;
            if (rst) begin
                alive[c] = 1'b0; alive[c-1] = 1'b0; alive[c-2] = 1'b0;
            end

            if (alive[c])        fo_exp = flg[c];
            else if (alive[c-1]) fo_exp = flg[c-1];
            else if (alive[c-2]) fo_exp = flg[c-2];
            else if (pw)         fo_exp = pd;
            else                 fo_exp = icc_m;

            if (!rst) check("rnd_flags_out", c, flags_out, fo_exp);
            check("rnd_icc", c, icc, icc_m);
            check("rnd_cc_pending", c, {3'b0, cc_pending}, {3'b0, pend_exp});

            if (rst)             icc_m = '0;
            else if (pw)         icc_m = pd;
            else if (alive[c-2]) icc_m = flg[c-2];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_producer_unit.md
# cc_producer_unit

Produces and holds the SPARC integer condition codes (icc) consumed by the branch condition logic in ID. Takes flag updates from cc-setting ALU instructions in EX, carries them through MEM and WB, and commits them to the architectural icc register in WB. Presents forwarded flags (newest in-flight value first) on `flags_out`, so a branch in ID evaluates against the most recent cc-setting instruction without waiting for commit.

## Interface
Parameters:
- FLAG_W, 4, flag vector width; bit order fixed: [0]=Z, [1]=N, [2]=C, [3]=V (identical to branch condition input)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX-stage instruction valid
- ex_cc_we  in  1  EX instruction sets icc (addcc, subcc, andcc, ...)
- ex_flags  in  4  ALU flags from EX, {V,C,N,Z}
- flush  in  1  kill younger-than-WB in-flight entries (mispredict / trap)
- psr_we  in  1  explicit icc write (wrpsr) committing in WB
- psr_wdata  in  4  icc value for psr_we, {V,C,N,Z}
- flags_out  out  4  forwarded icc to condition handler
- icc  out  4  architectural icc
- cc_pending  out  1  any cc-setting entry in MEM or WB stage

## Operation
- Internal regs: mem_v/mem_f (EX/MEM entry), wb_v/wb_f (MEM/WB entry), icc.
- Capture: ex_live = ex_valid & ex_cc_we & ~flush. On edge: mem_v<=ex_live, mem_f<=ex_flags.
- Advance: wb_v<=mem_v & ~flush, wb_f<=mem_f.
- Commit: if psr_we, icc<=psr_wdata; else if wb_v, icc<=wb_f. psr_we wins when both assert (same cycle, no program-order conflict at WB).
- WB entry is never flushed: it commits on the edge where it sits in WB regardless of flush.
- Forwarding (combinational, priority high→low): ex_live → ex_flags; mem_v → mem_f; wb_v → wb_f; psr_we → psr_wdata; else icc.
- cc_pending = mem_v | wb_v.
- Flag bit order is never permuted anywhere in the path; all outputs use [0]=Z,[1]=N,[2]=C,[3]=V.

## Timing
- Reset (synchronous): mem_v=0, wb_v=0, mem_f=0, wb_f=0, icc=4'b0000; next cycle flags_out=0, cc_pending=0 unless EX presents a live write.
- Reset mid-operation discards all in-flight entries; no commit occurs on the reset edge.
- Latency: cc instr in EX at cycle t → visible on flags_out in cycle t (bypass); in MEM cycle t+1; in WB cycle t+2; icc updated at end of t+2, visible on icc in t+3.
- Back-to-back cc writers: each cycle's EX value overrides older ones on flags_out; icc sequences through each value one cycle apart.
- flush at cycle t: EX input ignored, MEM entry dropped (not advanced to WB); WB entry commits at end of t. flags_out in cycle t skips EX and MEM sources.
- ex_cc_we with ex_valid=0: no effect.
- No stalls: block has no enable; pipeline freeze, if needed, is handled by holding ex_valid low (entries still drain).

## Test plan
- Reset: hold reset 2 cycles with ex_cc_we=1, ex_flags=4'hF → icc=0, flags_out=0 (except bypass when reset deasserted), cc_pending=0 after release.
- Single write: cycle t ex_valid=1, ex_cc_we=1, ex_flags=4'b0001 → flags_out=1 at t, t+1, t+2; cc_pending=1 at t+1,t+2; icc=4'b0001 at t+3.
- Back-to-back: flags 4'b0010, 4'b0100, 4'b1000 on t,t+1,t+2 → flags_out follows same cycles; icc = 2,4,8 at t+3,t+4,t+5.
- Flush: write 4'b0001 at t, 4'b0010 at t+1, flush at t+2 with ex 4'b0100 → 4'b0001 commits (icc=1 at t+3), 4'b0010 and 4'b0100 never commit; flags_out at t+2 = 4'b0001.
- psr_we vs WB collision: WB holds 4'b0011 while psr_we=1, psr_wdata=4'b1100 → icc=4'b1100 next cycle.
- ex_valid=0 with ex_cc_we=1, ex_flags=4'hF → no change to icc, flags_out, cc_pending.
